// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, parity, framing
// and break detection, feeding a small valid/ready receive FIFO.
module uart_rx_os #(
    parameter int MAX_DATA_W = 9,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clk_en_i,
    input  logic                            en_i,
    input  logic                            rx_i,
    input  logic [3:0]                      data_size_i,
    input  logic                            parity_en_i,
    input  logic                            parity_odd_i,
    input  logic [1:0]                      stop_size_i,
    output logic [MAX_DATA_W-1:0]           data_o,
    output logic                            parity_err_o,
    output logic                            frame_err_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            overrun_o,
    output logic                            break_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
    output logic [2:0]                      rx_state_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = MAX_DATA_W + 2;
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXW  = 4'(MAX_DATA_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        BRKWAIT = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic                  smp0_q, smp1_q;
    logic [TW-1:0]         tick_q, tick_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MAX_DATA_W-1:0] data_q, data_d;
    logic [3:0]            size_q, size_d, size_in;
    logic                  pen_q, pen_d, podd_q, podd_d;
    logic                  stop2_q, stop2_d;
    logic                  pbit_q, pbit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                  maj, mid, push, brk;
    logic [EW-1:0]         push_entry;

    assign mid = (tick_q == T_S2);
    assign maj = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign push_entry = {data_q, perr_q, ferr_q | ~maj};

    always_comb begin
        size_in = data_size_i;
        if (data_size_i < 4'd5) begin
            size_in = 4'd5;
        end else if (data_size_i > MAXW) begin
            size_in = MAXW;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        size_d  = size_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        stop2_d = stop2_q;
        pbit_d  = pbit_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        brk     = 1'b0;
        if (clk_en_i) begin
            tick_d = (tick_q == T_END) ? '0 : tick_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (en_i && rx_prev_q && !rx_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                        data_d  = '0;
                        pbit_d  = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        size_d  = size_in;
                        pen_d   = parity_en_i;
                        podd_d  = parity_odd_i;
                        stop2_d = (stop_size_i >= 2'd2);
                    end
                end
                START: begin
                    if (mid) begin
                        state_d = maj ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        for (int i = 0; i < MAX_DATA_W; i++) begin
                            if (cnt_q == 4'(i)) begin
                                data_d[i] = maj;
                            end
                        end
                        if (cnt_q == size_q - 1'b1) begin
                            cnt_d   = '0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        pbit_d  = maj;
                        perr_d  = (^data_q) ^ maj ^ podd_q;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        ferr_d = ferr_q | ~maj;
                        // pbit_q stays 0 when parity is off, so one test covers both
                        if (cnt_q == 4'd0 && !maj && data_q == '0 && !pbit_q) begin
                            push    = 1'b1;
                            brk     = 1'b1;
                            tick_d  = '0;
                            state_d = BRKWAIT;
                        end else if (stop2_q && cnt_q == 4'd0) begin
                            cnt_d = 4'd1;
                        end else begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                BRKWAIT: begin
                    if (!rx_s_q) begin
                        tick_d = '0;
                    end else if (tick_q == T_END) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            tick_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            size_q    <= 4'd5;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            stop2_q   <= 1'b0;
            pbit_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            if (clk_en_i) begin
                rx_prev_q <= rx_s_q;
                if (tick_q == T_S0) smp0_q <= rx_s_q;
                if (tick_q == T_S1) smp1_q <= rx_s_q;
            end
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            size_q  <= size_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            stop2_q <= stop2_d;
            pbit_q  <= pbit_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          ovr_q, brk_q;
    logic          full, pop, wr;
    logic [EW-1:0] head;

    assign full = (lvl_q == LW'(FIFO_DEPTH));
    assign pop  = valid_o & ready_i;
    // A pop in the same clk frees the slot the push needs
    assign wr   = push & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            ovr_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ovr_q <= push & full & ~pop;
            brk_q <= brk;
            if (wr) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(wr) - LW'(pop);
        end
    end

    assign head         = mem_q[rd_q];
    assign valid_o      = (lvl_q != '0);
    assign data_o       = valid_o ? head[EW-1:2] : '0;
    assign parity_err_o = valid_o & head[1];
    assign frame_err_o  = valid_o & head[0];
    assign overrun_o    = ovr_q;
    assign break_o      = brk_q;
    assign fifo_level_o = lvl_q;
    assign rx_state_o   = state_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame-level model of expected FIFO entries
// checked on every pop, plus literal timing and state expectations.
module tb_uart_rx_os;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clk_en_i = 1'b1;
    logic       en_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [3:0] data_size_i = 4'd8;
    logic       parity_en_i = 1'b0;
    logic       parity_odd_i = 1'b0;
    logic [1:0] stop_size_i = 2'd1;
    logic [8:0] data_o;
    logic       parity_err_o, frame_err_o, valid_o;
    logic       ready_i = 1'b1;
    logic       overrun_o, break_o;
    logic [2:0] fifo_level_o;
    logic [2:0] rx_state_o;

    always #5 clk_i = ~clk_i;

    uart_rx_os #(.MAX_DATA_W(9), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .en_i(en_i),
        .rx_i(rx_i), .data_size_i(data_size_i), .parity_en_i(parity_en_i),
        .parity_odd_i(parity_odd_i), .stop_size_i(stop_size_i),
        .data_o(data_o), .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o), .valid_o(valid_o), .ready_i(ready_i),
        .overrun_o(overrun_o), .break_o(break_o),
        .fifo_level_o(fifo_level_o), .rx_state_o(rx_state_o)
    );

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        front;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          div = 1;
    int          t_fall = 0;
    int          t_rise = 0;
    int          n_brk = 0;
    int          n_ovr = 0;
    int          exp_ovr = 0;
    logic [10:0] last_ent = '0;
    logic        vprev = 1'b0, bprev = 1'b0, oprev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            clk_en_i = (cyc % div == 0);
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && !vprev) t_rise = cyc;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {data_o, parity_err_o, frame_err_o}, 32'hFFFF);
                end else begin
                    front = exp_q.pop_front();
                    chk("pop_data", data_o, front.d);
                    chk("pop_perr", parity_err_o, front.pe);
                    chk("pop_ferr", frame_err_o, front.fe);
                end
                last_ent = {data_o, parity_err_o, frame_err_o};
            end
            if (!valid_o) chk("empty_zero", {data_o, parity_err_o, frame_err_o}, 0);
            if (break_o) n_brk++;
            if (overrun_o) n_ovr++;
            if ((break_o && bprev) || (overrun_o && oprev)) chk("pulse_width", 2, 1);
        end
        vprev = valid_o;
        bprev = break_o;
        oprev = overrun_o;
    end

    task automatic send_frame(input logic [8:0] d, input int nb,
                              input bit pen, input bit podd, input bit pflip,
                              input int nstop, input bit stop0,
                              input bit expect_push);
        logic [8:0] dm;
        logic       pbit;
        int         bclk;
        ent_t       e;
        bclk = 16 * div;
        dm = '0;
        for (int i = 0; i < nb; i++) dm[i] = d[i];
        pbit = (^dm) ^ podd ^ pflip;
        data_size_i  = 4'(nb);
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop_size_i  = (nstop == 2) ? 2'd2 : 2'd1;
        if (expect_push) begin
            e.d  = dm;
            e.pe = pen & pflip;
            e.fe = stop0;
            if (!ready_i && exp_q.size() >= 4) exp_ovr++;
            else exp_q.push_back(e);
        end
        rx_i = 1'b0;
        t_fall = cyc;
        hold(bclk);
        data_size_i  = 4'd5;
        parity_en_i  = ~pen;
        parity_odd_i = ~podd;
        stop_size_i  = (nstop == 2) ? 2'd0 : 2'd3;
        for (int i = 0; i < nb; i++) begin
            rx_i = dm[i];
            hold(bclk);
        end
        if (pen) begin
            rx_i = pbit;
            hold(bclk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_i = !(s == 0 && stop0);
            hold(bclk);
        end
        rx_i = 1'b1;
        hold(2 * bclk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold(3);
        rst_i = 1'b0;
        chk("rst_outs", {data_o, parity_err_o, frame_err_o, valid_o, overrun_o, break_o}, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_state", rx_state_o, 0);
        hold(5);

        send_frame(9'h0A5, 8, 0, 0, 0, 1, 0, 1);
        chk("t1_latency", t_rise - t_fall, 157);
        chk("t1_entry", last_ent, 11'h294);

        send_frame(9'h055, 7, 1, 0, 1, 1, 0, 1);
        chk("t2_7e1_entry", last_ent, 11'h156);
        send_frame(9'h1FF, 9, 1, 1, 0, 2, 0, 1);
        chk("t2_9o2_entry", last_ent, 11'h7FC);
        send_frame(9'h05A, 8, 0, 0, 0, 1, 1, 1);
        chk("ferr_entry", last_ent, 11'h169);
        chk("ferr_no_break", n_brk, 0);

        rx_i = 1'b0;
        hold(5);
        chk("glitch_start", rx_state_o, 1);
        hold(1);
        rx_i = 1'b1;
        hold(20);
        chk("glitch_idle", rx_state_o, 0);
        chk("glitch_level", fifo_level_o, 0);
        send_frame(9'h03C, 8, 0, 0, 0, 1, 0, 1);
        chk("t3_entry", last_ent, 11'h0F0);

        en_i = 1'b0;
        send_frame(9'h066, 8, 0, 0, 0, 1, 0, 0);
        chk("disabled_level", fifo_level_o, 0);
        en_i = 1'b1;

        data_size_i = 4'd8;
        parity_en_i = 1'b0;
        stop_size_i = 2'd1;
        front.d = '0;
        front.pe = 1'b0;
        front.fe = 1'b1;
        exp_q.push_back(front);
        rx_i = 1'b0;
        hold(192);
        chk("brk_state", rx_state_o, 5);
        rx_i = 1'b1;
        hold(8);
        rx_i = 1'b0;
        hold(20);
        rx_i = 1'b1;
        hold(40);
        chk("brk_entry", last_ent, 11'h001);
        send_frame(9'h081, 8, 0, 0, 0, 1, 0, 1);
        chk("t4_entry", last_ent, 11'h204);
        chk("brk_count", n_brk, 1);

        ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(9'(k), 8, 0, 0, 0, 1, 0, 1);
        chk("ovr_level", fifo_level_o, 4);
        chk("ovr_count", n_ovr, 1);
        chk("ovr_model", n_ovr, exp_ovr);
        ready_i = 1'b1;
        hold(10);
        chk("ovr_drained", fifo_level_o, 0);
        chk("ovr_last", last_ent, 11'h010);
        chk("model_empty", exp_q.size(), 0);

        div = 3;
        ready_i = 1'b0;
        send_frame(9'h011, 8, 0, 0, 0, 1, 0, 1);
        chk("t6_level", fifo_level_o, 1);
        data_size_i = 4'd8;
        rx_i = 1'b0;
        hold(48);
        rx_i = 1'b1;
        hold(48);
        hold(24);
        chk("t6_data_state", rx_state_o, 2);
        rst_i = 1'b1;
        hold(1);
        rst_i = 1'b0;
        exp_q.delete();
        chk("t6_rst_outs", {data_o, parity_err_o, frame_err_o, valid_o, overrun_o, break_o}, 0);
        chk("t6_rst_level", fifo_level_o, 0);
        chk("t6_rst_state", rx_state_o, 0);
        hold(96);
        ready_i = 1'b1;
        send_frame(9'h042, 8, 0, 0, 0, 1, 0, 1);
        chk("t6_entry", last_ent, 11'h108);
        chk("final_model_empty", exp_q.size(), 0);
        chk("final_brk_count", n_brk, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receiver for the peripheral UART. It supersedes the single-sample receiver with these additions: parametrised data width, majority-vote mid-bit sampling, false-start rejection, framing and break detection, and a small receive FIFO with a valid/ready output handshake. It sits between the pad-side rx line and the UART register block, and is driven by the baud generator's ×OVERSAMPLE tick.

Parameters:
MAX_DATA_W, 9, maximum data bits per frame (5..9).
OVERSAMPLE, 16, clk_en_i ticks per bit (even, ≥8).
FIFO_DEPTH, 4, receive FIFO entries (≥2, power of 2).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
clk_en_i  in  1  oversample tick, OVERSAMPLE per bit period
en_i  in  1  receiver enable; gates start detection only
rx_i  in  1  asynchronous serial input, idle high
data_size_i  in  4  data bits; <5 → 5, >MAX_DATA_W → MAX_DATA_W
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1 = odd, 0 = even parity
stop_size_i  in  2  stop bits; 0/1 → 1, 2/3 → 2
data_o  out  MAX_DATA_W  FIFO head data, right-justified, upper bits zero
parity_err_o  out  1  FIFO head parity error flag
frame_err_o  out  1  FIFO head framing error flag
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer pop; transfer when valid_o & ready_i
overrun_o  out  1  one-clk pulse: completed frame dropped, FIFO full
break_o  out  1  one-clk pulse: break detected
fifo_level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
rx_state_o  out  3  FSM state: IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 BRKWAIT=5

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state IDLE, FIFO empty.
  - All outputs 0; fifo_level_o 0.
  - The 2-flop rx synchroniser and the sample registers load 1.
  - Reset mid-frame discards the partial frame.
- rx_i passes through the 2-flop synchroniser (rx_s). All FSM and counter activity advances only on clk_en_i. FIFO push/pop and the output pulses act on clk_i.
- Tick counter (0..OVERSAMPLE-1):
  - Samples rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value is the 2-of-3 majority, decided at tick OVERSAMPLE/2+1.
- IDLE:
  - When en_i=1 and a 1→0 transition on rx_s is seen: zero the tick counter, go to START.
  - At this point, latch data_size, parity_en, parity_odd and stop_size. Config changes mid-frame have no effect.
- START: at the mid-bit decision, majority 1 → false start, return to IDLE with no frame and no flags. Majority 0 → DATA.
- DATA:
  - Shift the majority bit in, LSB first; after data_size bits → PARITY if parity_en, else STOP.
  - The stored word is right-justified.
- PARITY: sample the parity bit.
  - parity_err = XOR(data bits, parity bit) XOR parity_odd.
  - Even parity: XOR of data+parity must be 0. Odd parity: must be 1.
  - parity_err = 0 when parity is disabled.
- STOP:
  - Sample stop_size stop bits; any stop bit 0 → frame_err=1.
  - At the mid-bit decision of the last stop bit, push {data, parity_err, frame_err}, then go to IDLE. There is no wait for end of bit, which allows resync on early starts.
- Break:
  - Condition: data all 0, parity bit 0 (if enabled) and first stop bit 0.
  - Push the frame with frame_err=1, pulse break_o once, go to BRKWAIT.
  - BRKWAIT → IDLE once rx_s has been 1 for one full bit period (OVERSAMPLE ticks). No starts are detected while in BRKWAIT.
- en_i deassert mid-frame: the current frame completes normally; no new start is accepted.
- FIFO:
  - valid_o = level≠0. data_o, parity_err_o and frame_err_o show the head entry and are 0 when empty.
  - Pop on valid_o & ready_i. Push latency: valid_o rises the clk after the push decision.
  - Push when full with no simultaneous pop: frame dropped, FIFO unchanged, overrun_o pulses one clk.
  - Push when full with a simultaneous pop: push accepted, level unchanged, no overrun.
  - Push and pop when empty: the new entry is not visible until the next clk, so no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
All scenarios use OVERSAMPLE=16 and clk_en_i=1 every cycle unless noted.
1. 8N1 frame 0xA5, ready_i=1 → one valid_o beat, data_o=0x0A5, parity_err_o=0, frame_err_o=0; valid_o rises 1 clk after stop-bit mid-sample.
2. 7E1 frame 0x55 with parity bit forced 1 → data_o=0x055, parity_err_o=1, frame_err_o=0. Repeat with 9O2, data 0x1FF, correct parity → no errors, data_o=0x1FF.
3. Glitch: rx_i low for 6 ticks, then high → rx_state_o returns to 0 after START, no valid_o. A following 8N1 0x3C is received correctly.
4. Break: rx_i low for 12 bit times, 8N1 → exactly one entry (data 0x000, frame_err_o=1), one break_o pulse, no further entries until rx_i is high for 16 ticks. Then 0x81 is received correctly.
5. Overrun: FIFO_DEPTH=4, ready_i=0, five 8N1 frames 0x01..0x05 → fifo_level_o=4, one overrun_o pulse at the 5th frame. With ready_i=1, read 0x01,0x02,0x03,0x04 in order.
6. Reset mid-DATA of frame 0x77, clk_en_i every 3rd clk → all outputs 0, state 0, FIFO empty. The next frame 0x42 is received correctly.
